// File: rtl/uart_pkg.sv
// Shared constants and drain-FSM state encoding for the UART transmit path.
// Latency: none (declarations only).
// Backpressure: not applicable.
package uart_pkg;

    localparam int          BYTE_W   = 8;
    localparam logic [7:0]  ASCII_CR = 8'h0D;
    localparam logic [7:0]  ASCII_LF = 8'h0A;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        WAIT = 2'd2
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO; read data is the head entry, shown combinationally.
// Latency: a push is visible at the head (and in count) on the edge after it is sampled.
// Backpressure: pushes while full and pops while empty are ignored internally.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     RST,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage write; contents need no reset because count gates every read.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
        end
    end

    // Occupancy: simultaneous push and pop leave it unchanged.
    always_ff @(posedge clk) begin
        if (RST) begin
            count <= '0;
        end else begin
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding UartTx; optional LF -> CR,LF expansion under UART_TX_QUEUE_CRLF_EN.
// Latency: byte pushed at edge e0 is on tx_din with tx_enable at e1 when tx_ready is high.
// Backpressure: in_ready = !full; a byte offered while full is dropped and flags overflow.
module uart_tx_queue
    import uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              clr_overflow,
    output logic [BYTE_W-1:0] tx_din,
    output logic              tx_enable,
    input  logic              tx_ready,
    output logic [CW-1:0]     count,
    output logic              empty,
    output logic              full,
    output logic              overflow
);

    drain_state_t      state;
    drain_state_t      state_nxt;
    logic              push;
    logic              pop;
    logic              load;
    logic [BYTE_W-1:0] load_dat;
    logic [BYTE_W-1:0] head_dat;
`ifdef UART_TX_QUEUE_CRLF_EN
    logic              cr_sent;
    logic              cr_sent_nxt;
`endif

    // No bypass: in_ready depends only on the registered count.
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    sync_fifo #(
        .WIDTH (BYTE_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .RST     (RST),
        .push    (push),
        .wr_data (in_data),
        .pop     (pop),
        .rd_data (head_dat),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    // Drain decision: load the head when UartTx is ready, then wait out its busy period.
    always_comb begin
        state_nxt = state;
        load      = 1'b0;
        pop       = 1'b0;
        load_dat  = head_dat;
`ifdef UART_TX_QUEUE_CRLF_EN
        cr_sent_nxt = cr_sent;
`endif
        case (state)
            IDLE: begin
                if (!empty && tx_ready) begin
                    load      = 1'b1;
                    state_nxt = HOLD;
`ifdef UART_TX_QUEUE_CRLF_EN
                    // An LF at the head is preceded by a CR; the LF stays queued until then.
                    if (head_dat == ASCII_LF && !cr_sent) begin
                        load_dat    = ASCII_CR;
                        cr_sent_nxt = 1'b1;
                    end else begin
                        pop         = 1'b1;
                        cr_sent_nxt = 1'b0;
                    end
`else
                    pop = 1'b1;
`endif
                end
            end
            // UartTx lowers ready one cycle after sampling enable; skip that cycle.
            HOLD:    state_nxt = WAIT;
            WAIT:    if (tx_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Drain state register.
    always_ff @(posedge clk) begin
        if (RST) begin
            state <= IDLE;
`ifdef UART_TX_QUEUE_CRLF_EN
            cr_sent <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
`ifdef UART_TX_QUEUE_CRLF_EN
            cr_sent <= cr_sent_nxt;
`endif
        end
    end

    // Registered UartTx drive: enable is a one-cycle pulse, data held until the next load.
    always_ff @(posedge clk) begin
        if (RST) begin
            tx_enable <= 1'b0;
            tx_din    <= '0;
        end else begin
            tx_enable <= load;
            if (load) tx_din <= load_dat;
        end
    end

    // Sticky overflow; a new drop in the same cycle as a clear keeps it set.
    always_ff @(posedge clk) begin
        if (RST) begin
            overflow <= 1'b0;
        end else if (in_valid && full) begin
            overflow <= 1'b1;
        end else if (clr_overflow) begin
            overflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a small UartTx behavioural model.
// Latency: checks first load one edge after push, then order/values of every enable.
// Backpressure: tx_ready gated by the bench to fill the queue and force overflow.
`timescale 1ns/1ps
module tb_uart_tx_queue;
    import uart_pkg::*;

    localparam int DEPTH = 16;
    localparam int CW    = $clog2(DEPTH) + 1;
    localparam int CHAR  = 3;

    logic          clk = 1'b0;
    logic          RST = 1'b1;
    logic [7:0]    in_data = 8'h00;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          clr_overflow = 1'b0;
    logic [7:0]    tx_din;
    logic          tx_enable;
    logic          tx_ready;
    logic [CW-1:0] count;
    logic          empty;
    logic          full;
    logic          overflow;

    logic          allow = 1'b1;
    int            busy = 0;
    logic          prev_en = 1'b0;
    int            en_cnt = 0;
    int            total = 0;
    int            bad = 0;
    logic [7:0]    sb [$];

    uart_tx_queue #(.DEPTH(DEPTH)) dut (
        .clk          (clk),
        .RST          (RST),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .clr_overflow (clr_overflow),
        .tx_din       (tx_din),
        .tx_enable    (tx_enable),
        .tx_ready     (tx_ready),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    // UartTx model: samples enable while idle, then is busy for CHAR cycles.
    always @(posedge clk) begin
        if (RST)            busy <= 0;
        else if (busy != 0) busy <= busy - 1;
        else if (tx_enable) busy <= CHAR;
    end
    assign tx_ready = (busy == 0) && allow;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Monitor: every enable must carry the next expected byte and last one cycle.
    always @(negedge clk) begin
        if (tx_enable) begin
            en_cnt++;
            chk("pulse_width", {31'd0, prev_en}, 32'd0);
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_enable: got tx_din 0x%0h expected no enable", tx_din);
            end else begin
                chk("tx_din_order", {24'd0, tx_din}, {24'd0, sb.pop_front()});
            end
        end
        prev_en = tx_enable;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic sb_push(input logic [7:0] b);
`ifdef UART_TX_QUEUE_CRLF_EN
        if (b == ASCII_LF) sb.push_back(ASCII_CR);
`endif
        sb.push_back(b);
    endtask

    task automatic push_byte(input logic [7:0] b);
        in_valid = 1'b1;
        in_data  = b;
        if (in_ready) sb_push(b);
        tick;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain(input string nm);
        int guard = 0;
        while ((sb.size() != 0 || !empty || busy != 0) && guard < 3000) begin
            tick;
            guard++;
        end
        if (guard >= 3000) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: got %0d pending expected 0", nm, sb.size());
        end
        tick;
        tick;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int en_before;
        int guard;
        logic [7:0] d;

        // Reset state
        repeat (3) tick;
        RST = 1'b0;
        tick;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_tx_enable", 32'(tx_enable), 32'd0);
        chk("rst_tx_din", 32'(tx_din), 32'd0);
        chk("rst_overflow", 32'(overflow), 32'd0);

        // Single byte: enable one edge after push, count back to 0
        push_byte(8'h41);
        chk("single_count1", 32'(count), 32'd1);
        tick;
        chk("single_en", 32'(tx_enable), 32'd1);
        chk("single_din", 32'(tx_din), 32'h41);
        chk("single_count0", 32'(count), 32'd0);
        tick;
        chk("single_en_low", 32'(tx_enable), 32'd0);
        chk("single_din_hold", 32'(tx_din), 32'h41);
        wait_drain("single");

        // Burst to full with tx_ready held low
        allow = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            in_valid = 1'b1;
            in_data  = 8'(i);
            if (in_ready) sb_push(8'(i));
            tick;
        end
        in_valid = 1'b0;
        chk("burst_full", 32'(full), 32'd1);
        chk("burst_count", 32'(count), 32'd16);
        chk("burst_in_ready", 32'(in_ready), 32'd0);

        // Overflow: drop while full, clear, then set and clear together
        in_valid = 1'b1;
        in_data  = 8'hAA;
        tick;
        in_valid = 1'b0;
        chk("ovf_set", 32'(overflow), 32'd1);
        chk("ovf_count", 32'(count), 32'd16);
        clr_overflow = 1'b1;
        tick;
        clr_overflow = 1'b0;
        chk("ovf_clr", 32'(overflow), 32'd0);
        in_valid = 1'b1;
        clr_overflow = 1'b1;
        tick;
        in_valid = 1'b0;
        clr_overflow = 1'b0;
        chk("ovf_set_wins", 32'(overflow), 32'd1);
        tick;
        chk("ovf_sticky", 32'(overflow), 32'd1);
        clr_overflow = 1'b1;
        tick;
        clr_overflow = 1'b0;
        allow = 1'b1;
        wait_drain("burst");
        chk("burst_drained", 32'(count), 32'd0);

        // Simultaneous push and pop at count = 3
        allow = 1'b0;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        chk("sim_count_pre", 32'(count), 32'd3);
        allow    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h44;
        sb_push(8'h44);
        tick;
        in_valid = 1'b0;
        chk("sim_count_hold", 32'(count), 32'd3);
        chk("sim_enable", 32'(tx_enable), 32'd1);
        wait_drain("simul");

        // Streaming transfers with flow control; pointers wrap several times
        for (int i = 0; i < 40; i++) begin
            guard = 0;
            while (!in_ready && guard < 2000) begin
                in_valid = 1'b0;
                tick;
                guard++;
            end
            d = 8'(i * 7 + 3);
            in_valid = 1'b1;
            in_data  = d;
            sb_push(d);
            tick;
        end
        in_valid = 1'b0;
        wait_drain("wrap");
        chk("wrap_count", 32'(count), 32'd0);
        chk("wrap_no_ovf", 32'(overflow), 32'd0);

        // LF handling
        push_byte(8'h48);
        push_byte(ASCII_LF);
        wait_drain("crlf");
        chk("crlf_empty", 32'(empty), 32'd1);

        // Reset mid-drain while waiting on UartTx with five bytes queued
        allow = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(8'(8'h60 + i));
        allow = 1'b1;
        tick;
        tick;
        chk("mid_state_wait", 32'(dut.state), 32'(WAIT));
        chk("mid_count5", 32'(count), 32'd5);
        RST = 1'b1;
        sb.delete();
        en_before = en_cnt;
        tick;
        RST = 1'b0;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_enable", 32'(tx_enable), 32'd0);
        chk("mid_rst_idle", 32'(dut.state), 32'(IDLE));
        chk("mid_rst_din", 32'(tx_din), 32'd0);
        repeat (30) tick;
        chk("mid_rst_no_enable", 32'(en_cnt - en_before), 32'd0);
        chk("final_sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
